// File: rtl/pc_fetch_if.sv
// Instruction-memory request/grant/rvalid bus between pc_fetch (master) and the memory (slave).
interface pc_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/pc_fetch.sv
// PC register and instruction-fetch sequencer with a variable-latency req/gnt/rvalid memory port.
// Optional macro PC_FETCH_ALIGN_CHECK_EN: misaligned npc on retire traps to ERR instead of truncating.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        retire,
  output logic [31:0] pc,
  pc_fetch_if.master  imem,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] retire_cnt,
  output logic        fetch_err
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StErr} state_e;

  localparam logic [7:0] MaxWaitCnt = 8'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic        fetch_err_q, fetch_err_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic timeout;
  logic misalign;

  assign timeout = (state_q == StWait) && !imem.rvalid && ((wait_cnt_q + 8'd1) == MaxWaitCnt);

`ifdef PC_FETCH_ALIGN_CHECK_EN
  assign misalign = (npc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq:  if (imem.gnt) state_d = StWait;
      StWait: begin
        if (imem.rvalid) begin
          state_d = StHold;
        end else if (timeout) begin
          state_d = StErr;
        end
      end
      StHold: if (retire) state_d = misalign ? StErr : StReq;
      StErr:  state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    imem.req   = (state_q == StReq);
    imem.addr  = pc_q;
    pc         = pc_q;
    inst       = inst_q;
    inst_valid = inst_valid_q;
    retire_cnt = retire_cnt_q;
    fetch_err  = fetch_err_q;
  end

  // Datapath next-state
  always_comb begin
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    retire_cnt_d = retire_cnt_q;
    fetch_err_d  = fetch_err_q;
    wait_cnt_d   = wait_cnt_q;
    unique case (state_q)
      StReq: if (imem.gnt) wait_cnt_d = 8'd0;
      StWait: begin
        if (imem.rvalid) begin
          inst_d       = imem.rdata;
          inst_valid_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (timeout) fetch_err_d = 1'b1;
        end
      end
      StHold: begin
        if (retire) begin
          inst_valid_d = 1'b0;
          retire_cnt_d = retire_cnt_q + 32'd1;
          if (misalign) begin
            fetch_err_d = 1'b1;
          end else begin
`ifdef PC_FETCH_ALIGN_CHECK_EN
            pc_d = npc;
`else
            pc_d = npc & ~32'h3;
`endif
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      inst_valid_q <= 1'b0;
      retire_cnt_q <= 32'd0;
      fetch_err_q  <= 1'b0;
      wait_cnt_q   <= 8'd0;
    end else begin
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      retire_cnt_q <= retire_cnt_d;
      fetch_err_q  <= fetch_err_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed, table-driven bench for pc_fetch, built with MAX_WAIT=4 so the timeout is reachable.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] npc = 32'd0;
  logic        retire = 1'b0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] retire_cnt;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  pc_fetch_if imem ();

  pc_fetch #(
    .RESET_PC (32'h0000_0000),
    .MAX_WAIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .npc        (npc),
    .retire     (retire),
    .pc         (pc),
    .imem       (imem.master),
    .inst       (inst),
    .inst_valid (inst_valid),
    .retire_cnt (retire_cnt),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] npc;
    logic        retire;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] e_pc;
    logic        e_req;
    logic [31:0] e_inst;
    logic        e_iv;
    logic [31:0] e_rc;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] n, input logic r, input logic g, input logic v,
                              input logic [31:0] d, input logic [31:0] epc, input logic ereq,
                              input logic [31:0] einst, input logic eiv, input logic [31:0] erc,
                              input logic eerr);
    vec_t t;
    t.npc = n; t.retire = r; t.gnt = g; t.rvalid = v; t.rdata = d;
    t.e_pc = epc; t.e_req = ereq; t.e_inst = einst; t.e_iv = eiv; t.e_rc = erc; t.e_err = eerr;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] epc, input logic ereq,
                           input logic [31:0] einst, input logic eiv, input logic [31:0] erc,
                           input logic eerr);
    check({tag, " pc"}, pc, epc);
    check({tag, " addr"}, imem.addr, epc);
    check({tag, " req"}, {31'd0, imem.req}, {31'd0, ereq});
    check({tag, " inst"}, inst, einst);
    check({tag, " inst_valid"}, {31'd0, inst_valid}, {31'd0, eiv});
    check({tag, " retire_cnt"}, retire_cnt, erc);
    check({tag, " fetch_err"}, {31'd0, fetch_err}, {31'd0, eerr});
  endtask

  task automatic drive(input logic [31:0] n, input logic r, input logic g, input logic v,
                       input logic [31:0] d);
    npc = n; retire = r; imem.gnt = g; imem.rvalid = v; imem.rdata = d;
  endtask

  initial begin
    drive(32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Main sequence: first fetch, two retires, back-pressure, misaligned retire
    vecs.push_back(mk(32'h0, 0, 0, 0, 32'h0,          32'h0, 1, 32'h0, 0, 0, 0));
    vecs.push_back(mk(32'h0, 0, 1, 1, 32'hDEAD_BEEF,  32'h0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(32'h0, 0, 0, 1, 32'h0000_0013,  32'h0, 0, 32'h13, 1, 0, 0));
    vecs.push_back(mk(32'h0, 0, 0, 0, 32'h0,          32'h0, 0, 32'h13, 1, 0, 0));
    vecs.push_back(mk(32'h4, 1, 0, 0, 32'h0,          32'h4, 1, 32'h13, 0, 1, 0));
    vecs.push_back(mk(32'h4, 0, 1, 0, 32'h0,          32'h4, 0, 32'h13, 0, 1, 0));
    vecs.push_back(mk(32'h4, 0, 0, 1, 32'h00A0_0093,  32'h4, 0, 32'h00A0_0093, 1, 1, 0));
    vecs.push_back(mk(32'h8, 1, 0, 0, 32'h0,          32'h8, 1, 32'h00A0_0093, 0, 2, 0));
    vecs.push_back(mk(32'h40, 1, 0, 0, 32'h0,         32'h8, 1, 32'h00A0_0093, 0, 2, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(32'h40, 0, 0, 0, 32'h0,       32'h8, 1, 32'h00A0_0093, 0, 2, 0));
    vecs.push_back(mk(32'h40, 0, 1, 0, 32'h0,         32'h8, 0, 32'h00A0_0093, 0, 2, 0));
    vecs.push_back(mk(32'h50, 1, 0, 0, 32'h0,         32'h8, 0, 32'h00A0_0093, 0, 2, 0));
    vecs.push_back(mk(32'h50, 0, 0, 0, 32'h0,         32'h8, 0, 32'h00A0_0093, 0, 2, 0));
    vecs.push_back(mk(32'h50, 0, 0, 1, 32'h1111_1111, 32'h8, 0, 32'h1111_1111, 1, 2, 0));
`ifdef PC_FETCH_ALIGN_CHECK_EN
    vecs.push_back(mk(32'h102, 1, 0, 0, 32'h0,        32'h8, 0, 32'h1111_1111, 0, 3, 1));
`else
    vecs.push_back(mk(32'h102, 1, 0, 0, 32'h0,        32'h100, 1, 32'h1111_1111, 0, 3, 0));
`endif

    // Reset state
    @(posedge clk);
    #1 check_all("reset", 32'h0, 0, 32'h0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk) drive(vecs[i].npc, vecs[i].retire, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
      @(posedge clk);
      #1 check_all($sformatf("row%0d", i), vecs[i].e_pc, vecs[i].e_req, vecs[i].e_inst,
                   vecs[i].e_iv, vecs[i].e_rc, vecs[i].e_err);
    end

    // Timeout: grant, then no rvalid for MAX_WAIT cycles
    @(negedge clk) begin rst = 1'b1; drive(32'h0, 0, 0, 0, 32'h0); end
    #1 check_all("to_rst", 32'h0, 0, 32'h0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check_all("to_req", 32'h0, 1, 32'h0, 0, 0, 0);
    @(negedge clk) imem.gnt = 1'b1;
    @(posedge clk);
    #1 check_all("to_gnt", 32'h0, 0, 32'h0, 0, 0, 0);
    @(negedge clk) imem.gnt = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1 check_all($sformatf("to_wait%0d", k), 32'h0, 0, 32'h0, 0, 0, (k == 4));
    end
    @(negedge clk) drive(32'h200, 1, 1, 1, 32'hAAAA_5555);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 check_all($sformatf("err_hold%0d", k), 32'h0, 0, 32'h0, 0, 0, 1);
    end

    // Async reset mid-WAIT, then a late rvalid after release
    @(negedge clk) begin rst = 1'b1; drive(32'h0, 0, 0, 0, 32'h0); end
    #1 check_all("ar_rst", 32'h0, 0, 32'h0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    @(negedge clk) imem.gnt = 1'b1;
    @(posedge clk);
    @(negedge clk) drive(32'h0, 0, 0, 1, 32'h13);
    @(posedge clk);
    @(negedge clk) drive(32'h20, 1, 0, 0, 32'h0);
    @(posedge clk);
    #1 check_all("ar_retire", 32'h20, 1, 32'h13, 0, 1, 0);
    @(negedge clk) drive(32'h20, 0, 1, 0, 32'h0);
    @(posedge clk);
    #1 check_all("ar_wait", 32'h20, 0, 32'h13, 0, 1, 0);
    #2 begin rst = 1'b1; imem.gnt = 1'b0; end
    #1 check_all("ar_async", 32'h0, 0, 32'h0, 0, 0, 0);
    @(negedge clk) begin rst = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'h77; end
    @(posedge clk);
    #1 check_all("ar_late1", 32'h0, 1, 32'h0, 0, 0, 0);
    @(posedge clk);
    #1 check_all("ar_late2", 32'h0, 1, 32'h0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
